// File: rtl/tt_pkg.sv
// Shared types and helpers for the runtime-programmable truth-table evaluator.
package tt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  function automatic int rows(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_eval_if.sv
// Config, evaluation and result streams of the truth-table evaluator.
interface truth_table_eval_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [N_IN-1:0]  cfg_addr;
  logic [N_OUT-1:0] cfg_data;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_vec;
  logic             sweep_go;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_vec;
  logic [N_IN-1:0]  out_addr;
  logic             out_prog;
  logic             out_last;
  logic             busy;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, in_valid, in_vec, sweep_go, out_ready,
    input  cfg_ready, in_ready, out_valid, out_vec, out_addr, out_prog, out_last, busy
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, in_valid, in_vec, sweep_go, out_ready,
    output cfg_ready, in_ready, out_valid, out_vec, out_addr, out_prog, out_last, busy
  );
endinterface

// File: rtl/tt_row_mem.sv
// Truth-table storage: one write port, one async read port, plus a per-row
// "written since reset" bitmap. Only the bitmap is reset; row data is not.
module tt_row_mem
  import tt_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [N_IN-1:0]  waddr,
  input  logic [N_OUT-1:0] wdata,
  input  logic [N_IN-1:0]  raddr,
  output logic [N_OUT-1:0] rdata,
  output logic             rprog
);
  localparam int ROWS = rows(N_IN);

  logic [N_OUT-1:0] tbl_q [ROWS];
  logic [ROWS-1:0]  prog_q;

  always_ff @(posedge clk) begin
    if (we) tbl_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     prog_q <= '0;
    else if (we) prog_q[waddr] <= 1'b1;
  end

  assign rdata = tbl_q[raddr];
  assign rprog = prog_q[raddr];
endmodule

// File: rtl/truth_table_eval.sv
// N_IN-input / N_OUT-output programmable truth table with a registered,
// backpressured result stream and a full-table sweep (dump) mode.
module truth_table_eval
  import tt_pkg::*;
#(
  parameter int               N_IN    = 3,
  parameter int               N_OUT   = 1,
  parameter logic [N_OUT-1:0] DEF_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  truth_table_eval_if.slave bus
);
  localparam int              ROWS     = rows(N_IN);
  localparam logic [N_IN:0]   LAST_CNT = (N_IN+1)'(ROWS - 1);

  state_t           state_q, state_d;
  logic [N_IN:0]    cnt_q;
  logic             adv;
  logic             cfg_ready_c, in_ready_c, busy_c;
  logic             cfg_fire, in_fire, sweep_fire;
  logic [N_IN-1:0]  rd_addr;
  logic [N_OUT-1:0] rd_data;
  logic             rd_prog;

  logic             vld_p1;
  logic [N_OUT-1:0] vec_p1;
  logic [N_IN-1:0]  addr_p1;
  logic             prog_p1;
  logic             last_p1;

  assign adv = !vld_p1 || bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.sweep_go && !bus.cfg_valid) state_d = SWEEP;
      SWEEP:   if (vld_p1 && bus.out_ready && last_p1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A beat is only issued while cnt_q has not passed the last row, so the sweep never wraps.
  always_comb begin
    cfg_ready_c = !rst && (state_q == IDLE);
    in_ready_c  = !rst && (state_q == IDLE) && adv && !bus.cfg_valid && !bus.sweep_go;
    busy_c      = (state_q == SWEEP);
    sweep_fire  = !rst && (state_q == SWEEP) && adv && !cnt_q[N_IN];
  end

  assign cfg_fire = bus.cfg_valid && cfg_ready_c;
  assign in_fire  = bus.in_valid && in_ready_c;
  assign rd_addr  = (state_q == SWEEP) ? cnt_q[N_IN-1:0] : bus.in_vec;

  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE) cnt_q <= '0;
    else if (sweep_fire)        cnt_q <= cnt_q + 1'b1;
  end

  tt_row_mem #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_fire),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_data),
    .raddr (rd_addr),
    .rdata (rd_data),
    .rprog (rd_prog)
  );

  // Stage p1: result register, advanced whenever it is empty or being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      vec_p1  <= '0;
      addr_p1 <= '0;
      prog_p1 <= 1'b0;
      last_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= in_fire || sweep_fire;
      if (in_fire || sweep_fire) begin
        vec_p1  <= rd_prog ? rd_data : DEF_VAL;
        addr_p1 <= rd_addr;
        prog_p1 <= rd_prog;
        last_p1 <= sweep_fire && (cnt_q == LAST_CNT);
      end
    end
  end

  assign bus.cfg_ready = cfg_ready_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = vld_p1;
  assign bus.out_vec   = vec_p1;
  assign bus.out_addr  = addr_p1;
  assign bus.out_prog  = prog_p1;
  assign bus.out_last  = last_p1;
endmodule

// File: tb/tb_truth_table_eval.sv
// Bench for truth_table_eval: scoreboarded 3-in/1-out instance plus sweep-only
// instances at N_IN = 1, 4, 8 with a 3-bit non-zero default.
module tb_truth_table_eval;
  import tt_pkg::*;

  typedef struct packed {
    logic [2:0] addr;
    logic       vec;
    logic       prog;
    logic       last;
  } beat_t;

  typedef struct {
    logic [2:0] vec;
    logic       wr;
    logic       exp;
  } vrec_t;

  typedef logic [2:0] v3_arr_t [256];
  typedef int         i_arr_t  [256];
  typedef logic       b_arr_t  [256];

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   prm_go = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int acc_cnt = 0;

  beat_t      q[$];
  logic       m_tbl [8];
  logic [7:0] m_prog = '0;
  logic       m_sweep = 1'b0;
  vrec_t      vt [8];

  always #5 clk = ~clk;

  truth_table_eval_if #(.N_IN(3), .N_OUT(1)) bus ();

  truth_table_eval #(
    .N_IN    (3),
    .N_OUT   (1),
    .DEF_VAL (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  for (genvar g = 0; g < 3; g++) begin : g_prm
    localparam int NI = (g == 0) ? 1 : (g == 1) ? 4 : 8;
    localparam int NR = 1 << NI;

    truth_table_eval_if #(.N_IN(NI), .N_OUT(3)) pb ();

    truth_table_eval #(
      .N_IN    (NI),
      .N_OUT   (3),
      .DEF_VAL (3'b101)
    ) pdut (
      .clk (clk),
      .rst (rst),
      .bus (pb)
    );

    int      cap_n;
    v3_arr_t cap_vec;
    i_arr_t  cap_addr;
    b_arr_t  cap_prog;
    b_arr_t  cap_last;
    bit      done;

    initial begin
      pb.cfg_valid = 1'b0;
      pb.cfg_addr  = '0;
      pb.cfg_data  = '0;
      pb.in_valid  = 1'b0;
      pb.in_vec    = '0;
      pb.sweep_go  = 1'b0;
      pb.out_ready = 1'b1;
      cap_n = 0;
      done  = 1'b0;
      wait (prm_go);
      @(posedge clk); #1;
      pb.cfg_valid = 1'b1;
      pb.cfg_addr  = '1;
      pb.cfg_data  = 3'b010;
      @(posedge clk); #1;
      pb.cfg_valid = 1'b0;
      pb.sweep_go  = 1'b1;
      @(posedge clk); #1;
      pb.sweep_go  = 1'b0;
      for (int k = 0; k < NR + 10; k++) begin
        @(posedge clk); #1;
        if (pb.out_valid && cap_n < 256) begin
          cap_vec[cap_n]  = pb.out_vec;
          cap_addr[cap_n] = int'(pb.out_addr);
          cap_prog[cap_n] = pb.out_prog;
          cap_last[cap_n] = pb.out_last;
          cap_n++;
        end
      end
      done = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of the main instance: check readiness, update model/scoreboard, pop accepted beats.
  task automatic tick();
    logic  acc, stall, ifire, cfire, gofire, adv, was_rst;
    beat_t got;
    #1;
    was_rst = rst;
    adv     = !bus.out_valid || bus.out_ready;
    chk("cfg_ready", 64'(bus.cfg_ready), 64'(!rst && !m_sweep));
    chk("in_ready", 64'(bus.in_ready),
        64'(!rst && !m_sweep && adv && !bus.cfg_valid && !bus.sweep_go));
    acc    = !rst && bus.out_valid && bus.out_ready;
    stall  = !rst && bus.out_valid && !bus.out_ready;
    ifire  = !rst && bus.in_valid && bus.in_ready;
    cfire  = !rst && bus.cfg_valid && bus.cfg_ready;
    gofire = !rst && !m_sweep && bus.sweep_go && !bus.cfg_valid;
    got    = '{bus.out_addr, bus.out_vec, bus.out_prog, bus.out_last};
    if (ifire)
      q.push_back('{bus.in_vec, m_prog[bus.in_vec] ? m_tbl[bus.in_vec] : 1'b0,
                    m_prog[bus.in_vec], 1'b0});
    if (gofire) begin
      for (int r = 0; r < 8; r++)
        q.push_back('{3'(r), m_prog[r] ? m_tbl[r] : 1'b0, m_prog[r], (r == 7)});
      m_sweep = 1'b1;
    end
    if (cfire) begin
      m_tbl[bus.cfg_addr]  = bus.cfg_data;
      m_prog[bus.cfg_addr] = 1'b1;
    end
    @(posedge clk); #1;
    if (was_rst) begin
      q.delete();
      m_prog  = '0;
      m_sweep = 1'b0;
    end
    if (acc) begin
      acc_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_beat", 64'(got), 64'(0));
        if (got == '0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got a zero beat, expected none");
        end
      end else begin
        beat_t e;
        e = q.pop_front();
        chk("beat", 64'(got), 64'(e));
        if (e.last) m_sweep = 1'b0;
      end
    end
    if (stall)
      chk("hold", 64'({bus.out_valid, bus.out_addr, bus.out_vec, bus.out_prog, bus.out_last}),
          64'({1'b1, got}));
  endtask

  task automatic chk_prm(input int ni, input int n, input v3_arr_t v, input i_arr_t a,
                         input b_arr_t p, input b_arr_t l);
    int         nr;
    logic [2:0] ev;
    nr = 1 << ni;
    chk("prm_len", 64'(n), 64'(nr));
    for (int i = 0; i < n && i < 256; i++) begin
      ev = (i == nr - 1) ? 3'b010 : 3'b101;
      chk("prm_beat", 64'({a[i], v[i], p[i], l[i]}),
          64'({i, ev, (i == nr - 1), (i == nr - 1)}));
    end
  endtask

  initial begin
    int base;
    for (int i = 0; i < 8; i++) begin
      vt[i] = '{3'(i), (i == 6), (i == 6)};
      m_tbl[i] = 1'b0;
    end
    bus.cfg_valid = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.sweep_go  = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) tick();
    chk("rst_out", 64'({bus.out_valid, bus.out_vec, bus.out_addr, bus.out_prog, bus.out_last}), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    rst = 1'b0;
    tick();

    // Defaults: unprogrammed row 110.
    bus.in_valid = 1'b1;
    bus.in_vec   = 3'b110;
    tick();
    bus.in_valid = 1'b0;
    chk("dflt_valid", 64'(bus.out_valid), 64'(1));
    chk("dflt_beat", 64'({bus.out_addr, bus.out_vec, bus.out_prog, bus.out_last}), 64'({3'b110, 3'b000}));
    tick();

    // AND-NOT gate programming and back-to-back evaluation.
    bus.cfg_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.cfg_addr = vt[i].vec;
      bus.cfg_data = vt[i].wr;
      tick();
    end
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_vec = vt[i].vec;
      tick();
      chk("andnot_vec", 64'(bus.out_vec), 64'(vt[i].exp));
      chk("andnot_addr", 64'({bus.out_valid, bus.out_addr, bus.out_prog}), 64'({1'b1, vt[i].vec, 1'b1}));
    end
    bus.in_valid = 1'b0;
    tick();

    // Sweep with alternating backpressure.
    bus.cfg_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.cfg_addr = 3'(i);
      bus.cfg_data = (i == 0 || i == 5);
      tick();
    end
    bus.cfg_valid = 1'b0;
    bus.sweep_go  = 1'b1;
    tick();
    bus.sweep_go  = 1'b0;
    base = acc_cnt;
    for (int k = 0; k < 60 && acc_cnt - base < 8; k++) begin
      bus.out_ready = (k % 2 == 0);
      tick();
      if (acc_cnt - base < 8) chk("sweep_busy", 64'(bus.busy), 64'(1));
    end
    chk("sweep_beats", 64'(acc_cnt - base), 64'(8));
    chk("sweep_done_busy", 64'(bus.busy), 64'(0));
    bus.out_ready = 1'b1;
    tick();

    // Config beats eval on the same row; eval follows with the new value.
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 3'd2;
    bus.cfg_data  = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_vec    = 3'd2;
    #1;
    chk("prio_in_ready", 64'({bus.cfg_ready, bus.in_ready}), 64'(2'b10));
    tick();
    bus.cfg_valid = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    chk("prio_new_val", 64'({bus.out_valid, bus.out_addr, bus.out_vec}), 64'({1'b1, 3'd2, 1'b1}));
    tick();

    // Reset in the middle of a sweep.
    bus.sweep_go = 1'b1;
    tick();
    bus.sweep_go = 1'b0;
    base = acc_cnt;
    for (int k = 0; k < 20 && acc_cnt - base < 3; k++) tick();
    chk("mid_beats", 64'(acc_cnt - base), 64'(3));
    rst = 1'b1;
    tick();
    chk("mid_rst", 64'({bus.out_valid, bus.busy}), 64'(0));
    rst = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_vec = vt[i].vec;
      tick();
      chk("post_rst", 64'({bus.out_valid, bus.out_vec, bus.out_prog}), 64'(3'b100));
    end
    bus.in_valid = 1'b0;
    tick();

    // Parameterised sweeps with a non-zero default.
    prm_go = 1'b1;
    for (int k = 0; k < 400 && !(g_prm[0].done && g_prm[1].done && g_prm[2].done); k++) tick();
    chk("prm_done", 64'({g_prm[0].done, g_prm[1].done, g_prm[2].done}), 64'(3'b111));
    chk_prm(1, g_prm[0].cap_n, g_prm[0].cap_vec, g_prm[0].cap_addr, g_prm[0].cap_prog, g_prm[0].cap_last);
    chk_prm(4, g_prm[1].cap_n, g_prm[1].cap_vec, g_prm[1].cap_addr, g_prm[1].cap_prog, g_prm[1].cap_last);
    chk_prm(8, g_prm[2].cap_n, g_prm[2].cap_vec, g_prm[2].cap_addr, g_prm[2].cap_prog, g_prm[2].cap_last);

    chk("sb_empty", 64'(q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
